// File: rtl/bm_stmt_compare_arbiter.sv
// Two-requester round-robin arbiter in front of one registered padded-compare unit.
// Each grant latches a/b, evaluates for one cycle, then strobes done for the winner.
module bm_stmt_compare_arbiter #(
  parameter int BITS  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [BITS-1:0]  a0,
  input  logic             b0,
  input  logic             req1,
  input  logic [BITS-1:0]  a1,
  input  logic             b1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             gnt_id,
  output logic [BITS-1:0]  res_code,
  output logic             res_eq,
  output logic             res_lt,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [BITS-1:0] op_a;
  logic            op_b;
  logic            rr_ptr;   // requester favoured on a tie
  logic            win_id;
  logic [BITS-1:0] b_ext;
  logic [BITS-1:0] code_next;

  // NOTE: combinational blocks assign every output up front so no path infers a latch.
  always_comb begin
    win_id = 1'b0;
    if (req0 && req1) win_id = rr_ptr;
    else if (req1)    win_id = 1'b1;
  end

  // Case labels are one bit narrower than a: any a with its top bit set falls
  // through to the zero default; otherwise the code is all-ones minus a.
  always_comb begin
    b_ext     = {{(BITS-1){1'b0}}, op_b};
    code_next = op_a[BITS-1] ? '0 : ~op_a;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= 1'b0;
      gnt_id    <= 1'b0;
      rr_ptr    <= 1'b0;
      res_code  <= '0;
      res_eq    <= 1'b0;
      res_lt    <= 1'b0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id <= win_id;
            op_a   <= win_id ? a1 : a0;
            op_b   <= win_id ? b1 : b0;
            state  <= EVAL;
          end
        end
        EVAL: begin
          res_code <= code_next;
          res_eq   <= (op_a == b_ext);
          res_lt   <= (op_a < b_ext);
          state    <= DONE;
        end
        DONE: begin
          txn_count <= txn_count + CNT_W'(1);
          rr_ptr    <= ~gnt_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done0 = (state == DONE) && !gnt_id;
  assign done1 = (state == DONE) &&  gnt_id;

endmodule

// File: tb/tb_bm_stmt_compare_arbiter.sv
// Self-checking bench: vector table of transactions, scoreboard of expected
// results, plus hand-written tie, reset-abort and counter-wrap sequences.
module tb_bm_stmt_compare_arbiter;

  logic       clock;
  logic       reset;
  logic       req0, b0, req1, b1;
  logic [3:0] a0, a1;
  logic       done0, done1, busy, gnt_id, res_eq, res_lt;
  logic [3:0] res_code;
  logic [7:0] txn_count;

  bm_stmt_compare_arbiter #(.BITS(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .busy(busy), .gnt_id(gnt_id),
    .res_code(res_code), .res_eq(res_eq), .res_lt(res_lt),
    .txn_count(txn_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       r0;
    logic [3:0] a0;
    logic       b0;
    logic       r1;
    logic [3:0] a1;
    logic       b1;
    logic       id;
    logic [3:0] code;
    logic       eq;
    logic       lt;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] code;
    logic       eq;
    logic       lt;
  } exp_t;

  vec_t       vecs[14];
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [3:0] a, input logic b);
    exp_t e;
    e.id   = id;
    e.code = (a <= 4'd7) ? (4'd15 - a) : 4'd0;
    e.eq   = (a == {3'b000, b});
    e.lt   = (a < {3'b000, b});
    return e;
  endfunction

  // Waits for a done strobe at negedges; pops and compares the scoreboard head.
  task automatic watch_done(input int max_cycles, output int waited);
    exp_t e;
    waited = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clock);
      if (done0 || done1) begin
        waited = i;
        check("done_exclusive", {31'd0, done0 && done1}, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_id", {31'd0, done1}, {31'd0, e.id});
          check("res_code", {28'd0, res_code}, {28'd0, e.code});
          check("res_eq", {31'd0, res_eq}, {31'd0, e.eq});
          check("res_lt", {31'd0, res_lt}, {31'd0, e.lt});
        end
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    int   w;
    @(posedge clock); #1;
    check("idle_busy", {31'd0, busy}, 0);
    check("txn_count", {24'd0, txn_count}, {24'd0, exp_count});
    req0 = v.r0; a0 = v.a0; b0 = v.b0;
    req1 = v.r1; a1 = v.a1; b1 = v.b1;
    e.id = v.id; e.code = v.code; e.eq = v.eq; e.lt = v.lt;
    sb.push_back(e);
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    check("busy_eval", {31'd0, busy}, 1);
    check("gnt_id", {31'd0, gnt_id}, {31'd0, v.id});
    // operands move during EVAL; the latched copy must be what gets evaluated
    a0 = 4'($urandom); b0 = 1'($urandom);
    a1 = 4'($urandom); b1 = 1'($urandom);
    watch_done(6, w);
    check("latency", w, 2);
    exp_count = exp_count + 8'd1;
  endtask

  initial begin
    vec_t v;
    exp_t e0, e1;
    int   w;
    logic saw_done;

    reset = 1'b1;
    req0 = 1'b0; a0 = 4'd0; b0 = 1'b0;
    req1 = 1'b0; a1 = 4'd0; b1 = 1'b0;

    vecs[0] = '{r0:1, a0:3, b0:0, r1:0, a1:0, b1:0, id:0, code:12, eq:0, lt:0};
    vecs[1] = '{r0:0, a0:0, b0:0, r1:1, a1:1, b1:1, id:1, code:14, eq:1, lt:0};
    vecs[2] = '{r0:0, a0:0, b0:0, r1:1, a1:0, b1:1, id:1, code:15, eq:0, lt:1};
    vecs[3] = '{r0:1, a0:0, b0:0, r1:0, a1:0, b1:0, id:0, code:15, eq:1, lt:0};
    for (int i = 0; i < 8; i++)
      vecs[4+i] = '{r0:1, a0:4'(8+i), b0:0, r1:0, a1:0, b1:0, id:0, code:0, eq:0, lt:0};
    // ties after serving 0, then after serving 1
    vecs[12] = '{r0:1, a0:5, b0:1, r1:1, a1:7, b1:0, id:1, code:8, eq:0, lt:0};
    vecs[13] = '{r0:1, a0:1, b0:1, r1:1, a1:9, b1:0, id:0, code:14, eq:1, lt:0};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {30'd0, done1, done0}, 0);
    check("rst_gnt", {31'd0, gnt_id}, 0);
    check("rst_res", {26'd0, res_code, res_eq, res_lt}, 0);
    check("rst_count", {24'd0, txn_count}, 0);

    for (int i = 0; i < 14; i++) do_txn(vecs[i]);

    // Both held: last served was 0, so grants go 1,0,1,0 every 3 cycles
    @(posedge clock); #1;
    req0 = 1'b1; a0 = 4'd2; b0 = 1'b0;
    req1 = 1'b1; a1 = 4'd1; b1 = 1'b0;
    e0 = model(1'b0, 4'd2, 1'b0);
    e1 = model(1'b1, 4'd1, 1'b0);
    sb.push_back(e1); sb.push_back(e0); sb.push_back(e1); sb.push_back(e0);
    for (int i = 0; i < 4; i++) begin
      watch_done(6, w);
      check("hold_spacing", w, 3);
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_count = exp_count + 8'd4;

    // Reset during EVAL aborts with no strobe
    @(posedge clock); #1;
    check("pre_abort_count", {24'd0, txn_count}, {24'd0, exp_count});
    req0 = 1'b1; a0 = 4'd5; b0 = 1'b0;
    @(posedge clock); #1;
    req0 = 1'b0;
    check("abort_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy0", {31'd0, busy}, 0);
    check("abort_done", {30'd0, done1, done0}, 0);
    check("abort_gnt", {31'd0, gnt_id}, 0);
    check("abort_res", {26'd0, res_code, res_eq, res_lt}, 0);
    check("abort_count", {24'd0, txn_count}, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done0 || done1) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 0);
    exp_count = 8'd0;

    // Tie right after reset goes to requester 0
    v = '{r0:1, a0:6, b0:0, r1:1, a1:0, b1:1, id:0, code:9, eq:0, lt:0};
    do_txn(v);

    // Fill to 256 completions and confirm the counter wraps
    for (int i = 1; i < 256; i++) begin
      e0 = model(1'b0, 4'(i), 1'(i >> 4));
      v = '{r0:1, a0:4'(i), b0:1'(i >> 4), r1:0, a1:0, b1:0,
            id:0, code:e0.code, eq:e0.eq, lt:e0.lt};
      do_txn(v);
    end
    @(posedge clock); #1;
    check("txn_wrap", {24'd0, txn_count}, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
